// File: rtl/rmio_eu_port_if.sv
// rtl/rmio_eu_port_if.sv - core-facing row streams of the RMIO execution-unit port
interface rmio_eu_port_if #(
    parameter int DATA_W = 1408
) ();
    logic              core_in_valid;
    logic              core_in_ready;
    logic [DATA_W-1:0] core_in_data;
    logic              core_out_valid;
    logic              core_out_ready;
    logic [DATA_W-1:0] core_out_data;

    modport master (
        output core_in_valid, core_in_data, core_out_ready,
        input  core_in_ready, core_out_valid, core_out_data
    );

    modport slave (
        input  core_in_valid, core_in_data, core_out_ready,
        output core_in_ready, core_out_valid, core_out_data
    );
endinterface

// File: rtl/rmio_eu_port.sv
// rtl/rmio_eu_port.sv - RMIO endpoint: input row FIFO to core, core results to 1-cycle read port
// Optional sticky overflow/underflow flags with err_clr when RMIO_PORT_ERR_EN is defined.
module rmio_eu_port #(
    parameter int DATA_W    = 1408,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         input_we,
    input  logic [DATA_W-1:0]            input_data,
    input  logic                         output_re,
    output logic [DATA_W-1:0]            output_data,
    input  logic                         flush,
    rmio_eu_port_if.master               core,
    output logic [$clog2(IN_DEPTH):0]    in_count,
    output logic [$clog2(OUT_DEPTH):0]   out_count,
`ifdef RMIO_PORT_ERR_EN
    output logic                         err_ovf,
    output logic                         err_udf,
    input  logic                         err_clr,
`endif
    output logic                         busy
);
    localparam int IN_PW  = $clog2(IN_DEPTH);
    localparam int OUT_PW = $clog2(OUT_DEPTH);
    localparam int IN_CW  = IN_PW + 1;
    localparam int OUT_CW = OUT_PW + 1;
    localparam logic [IN_CW-1:0]  IN_FULL  = IN_CW'(IN_DEPTH);
    localparam logic [OUT_CW-1:0] OUT_FULL = OUT_CW'(OUT_DEPTH);

    logic [DATA_W-1:0] in_mem_q  [IN_DEPTH];
    logic [DATA_W-1:0] in_mem_d  [IN_DEPTH];
    logic [DATA_W-1:0] out_mem_q [OUT_DEPTH];
    logic [DATA_W-1:0] out_mem_d [OUT_DEPTH];
    logic [IN_PW-1:0]  in_wr_ptr_q, in_wr_ptr_d, in_rd_ptr_q, in_rd_ptr_d;
    logic [OUT_PW-1:0] out_wr_ptr_q, out_wr_ptr_d, out_rd_ptr_q, out_rd_ptr_d;
    logic [IN_CW-1:0]  in_count_q, in_count_d;
    logic [OUT_CW-1:0] out_count_q, out_count_d;
    logic [DATA_W-1:0] output_data_q, output_data_d;

    logic in_push, in_pop, out_push, out_pop, ovf_evt, udf_evt;

    always_comb begin
        // A core pop in the same cycle frees the slot a full-FIFO write needs.
        in_pop   = (|in_count_q) & core.core_in_ready;
        in_push  = input_we & ((in_count_q != IN_FULL) | in_pop);
        ovf_evt  = input_we & ~in_push;
        out_push = core.core_out_valid & (out_count_q != OUT_FULL);
        out_pop  = output_re & (|out_count_q);
        udf_evt  = output_re & ~(|out_count_q);
    end

    always_comb begin
        in_mem_d     = in_mem_q;
        out_mem_d    = out_mem_q;
        in_wr_ptr_d  = in_wr_ptr_q;
        in_rd_ptr_d  = in_rd_ptr_q;
        out_wr_ptr_d = out_wr_ptr_q;
        out_rd_ptr_d = out_rd_ptr_q;
        in_count_d   = in_count_q;
        out_count_d  = out_count_q;
        output_data_d = output_data_q;

        if (flush) begin
            in_wr_ptr_d  = '0;
            in_rd_ptr_d  = '0;
            out_wr_ptr_d = '0;
            out_rd_ptr_d = '0;
            in_count_d   = '0;
            out_count_d  = '0;
        end else begin
            if (in_push) begin
                in_mem_d[in_wr_ptr_q] = input_data;
                in_wr_ptr_d = in_wr_ptr_q + 1'b1;
            end
            if (in_pop) begin
                in_rd_ptr_d = in_rd_ptr_q + 1'b1;
            end
            case ({in_push, in_pop})
                2'b10:   in_count_d = in_count_q + 1'b1;
                2'b01:   in_count_d = in_count_q - 1'b1;
                default: in_count_d = in_count_q;
            endcase

            if (out_push) begin
                out_mem_d[out_wr_ptr_q] = core.core_out_data;
                out_wr_ptr_d = out_wr_ptr_q + 1'b1;
            end
            // Underflow returns zeros rather than stale storage.
            if (out_pop) begin
                out_rd_ptr_d  = out_rd_ptr_q + 1'b1;
                output_data_d = out_mem_q[out_rd_ptr_q];
            end else if (udf_evt) begin
                output_data_d = '0;
            end
            case ({out_push, out_pop})
                2'b10:   out_count_d = out_count_q + 1'b1;
                2'b01:   out_count_d = out_count_q - 1'b1;
                default: out_count_d = out_count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_mem_q      <= '{default: '0};
            out_mem_q     <= '{default: '0};
            in_wr_ptr_q   <= '0;
            in_rd_ptr_q   <= '0;
            out_wr_ptr_q  <= '0;
            out_rd_ptr_q  <= '0;
            in_count_q    <= '0;
            out_count_q   <= '0;
            output_data_q <= '0;
        end else begin
            in_mem_q      <= in_mem_d;
            out_mem_q     <= out_mem_d;
            in_wr_ptr_q   <= in_wr_ptr_d;
            in_rd_ptr_q   <= in_rd_ptr_d;
            out_wr_ptr_q  <= out_wr_ptr_d;
            out_rd_ptr_q  <= out_rd_ptr_d;
            in_count_q    <= in_count_d;
            out_count_q   <= out_count_d;
            output_data_q <= output_data_d;
        end
    end

`ifdef RMIO_PORT_ERR_EN
    logic err_ovf_q, err_ovf_d, err_udf_q, err_udf_d;

    // Set has priority over a simultaneous clear; flush leaves the flags alone.
    always_comb begin
        err_ovf_d = (err_ovf_q & ~err_clr) | ovf_evt;
        err_udf_d = (err_udf_q & ~err_clr) | udf_evt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            err_ovf_q <= err_ovf_d;
            err_udf_q <= err_udf_d;
        end
    end

    assign err_ovf = err_ovf_q;
    assign err_udf = err_udf_q;
`else
    logic unused_evt;
    assign unused_evt = ovf_evt ^ udf_evt;
`endif

    assign core.core_in_valid  = |in_count_q;
    assign core.core_in_data   = in_mem_q[in_rd_ptr_q];
    assign core.core_out_ready = (out_count_q != OUT_FULL);
    assign output_data         = output_data_q;
    assign in_count            = in_count_q;
    assign out_count           = out_count_q;
    assign busy                = (|in_count_q) | (|out_count_q) | core.core_out_valid;
endmodule
